// File: rtl/nn_infer_seq.sv
// nn_infer_seq: inference sequencer for the digit-classifier datapath.
// Collects a pixel frame from a valid/ready stream into a flat buffer,
// runs the two layer engines back-to-back via start/done pulses, then
// performs a streaming argmax over the logits and presents class, margin
// and frame-error status on a valid/ready result port.
module nn_infer_seq #(
    parameter int N_PIX        = 64,
    parameter int PIX_BITS     = 2,
    parameter int PIX_PER_BEAT = 4,
    parameter int N_CLASSES    = 10,
    parameter int LOGIT_W      = 6,
    localparam int CLS_W       = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [PIX_PER_BEAT*PIX_BITS-1:0] s_data,
    input  logic                             s_last,
    input  logic                             abort,
    output logic [N_PIX*PIX_BITS-1:0]        pix_flat,
    output logic                             l1_start,
    output logic                             l2_start,
    input  logic                             l1_done,
    input  logic                             l2_done,
    output logic [CLS_W-1:0]                 logit_addr,
    input  logic signed [LOGIT_W-1:0]        logit_data,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [CLS_W-1:0]                 res_class,
    output logic [LOGIT_W-1:0]               res_margin,
    output logic                             res_err,
    output logic                             busy
);

    localparam int BEATS  = N_PIX / PIX_PER_BEAT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] ST_LOAD   = 3'd0;
    localparam logic [2:0] ST_L1     = 3'd1;
    localparam logic [2:0] ST_L2     = 3'd2;
    localparam logic [2:0] ST_ARG    = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;

    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CLS_W-1:0]          LAST_IDX  = CLS_W'(N_CLASSES - 1);
    localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

    // best - second is never negative and at most 2^LOGIT_W-1, so the low
    // LOGIT_W bits of the sign-extended difference are the exact margin.
    function automatic logic [LOGIT_W-1:0] margin_f(
        input logic signed [LOGIT_W-1:0] hi,
        input logic signed [LOGIT_W-1:0] lo
    );
        logic [LOGIT_W:0] diff;
        diff = {hi[LOGIT_W-1], hi} - {lo[LOGIT_W-1], lo};
        return diff[LOGIT_W-1:0];
    endfunction

    logic [2:0]                  state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        err_q, err_d;
    logic                        l1_start_q, l1_start_d;
    logic                        l2_start_q, l2_start_d;
    logic [CLS_W-1:0]            idx_q, idx_d;
    logic signed [LOGIT_W-1:0]   best_q, best_d;
    logic signed [LOGIT_W-1:0]   second_q, second_d;
    logic [CLS_W-1:0]            cls_q, cls_d;
    logic                        res_valid_q, res_valid_d;
    logic [CLS_W-1:0]            res_class_q, res_class_d;
    logic [LOGIT_W-1:0]          res_margin_q, res_margin_d;
    logic                        res_err_q, res_err_d;

    logic signed [LOGIT_W-1:0]   arg_best_s;
    logic signed [LOGIT_W-1:0]   arg_second_s;
    logic [CLS_W-1:0]            arg_cls_s;
    logic                        pix_we_s;
    logic [PIX_BITS-1:0]         pix_q [N_PIX];

    assign s_ready    = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_ARG);
    assign l1_start   = l1_start_q;
    assign l2_start   = l2_start_q;
    assign logit_addr = idx_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_margin = res_margin_q;
    assign res_err    = res_err_q;

    // An abort cycle never writes the buffer, even if a beat is offered.
    assign pix_we_s = (state_q == ST_LOAD) && s_valid && !abort;

    // Pixel buffer: each pixel owns a register loaded from its lane on its beat.
    for (genvar k = 0; k < N_PIX; k++) begin : g_pix
        localparam int                 LANE = k % PIX_PER_BEAT;
        localparam logic [BEAT_W-1:0]  KB   = BEAT_W'(k / PIX_PER_BEAT);

        // Capture this pixel when its beat is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pix_q[k] <= {PIX_BITS{1'b0}};
            end else if (pix_we_s && (beat_q == KB)) begin
                pix_q[k] <= s_data[LANE*PIX_BITS +: PIX_BITS];
            end
        end

        assign pix_flat[k*PIX_BITS +: PIX_BITS] = pix_q[k];
    end

    // Streaming argmax step: fold the current logit into best/second.
    always_comb begin
        arg_best_s   = best_q;
        arg_second_s = second_q;
        arg_cls_s    = cls_q;
        if (idx_q == {CLS_W{1'b0}}) begin
            arg_best_s   = logit_data;
            arg_second_s = LOGIT_MIN;
            arg_cls_s    = {CLS_W{1'b0}};
        end else if (logit_data > best_q) begin
            arg_second_s = best_q;
            arg_best_s   = logit_data;
            arg_cls_s    = idx_q;
        end else if (logit_data > second_q) begin
            arg_second_s = logit_data;
        end else begin
            arg_second_s = second_q;
        end
    end

    // Sequencer next-state logic; abort overrides everything at the end.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        err_d        = err_q;
        l1_start_d   = 1'b0;
        l2_start_d   = 1'b0;
        idx_d        = idx_q;
        best_d       = best_q;
        second_d     = second_q;
        cls_d        = cls_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_margin_d = res_margin_q;
        res_err_d    = res_err_q;

        case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        // Full frame: process it even if s_last was missing.
                        state_d    = ST_L1;
                        l1_start_d = 1'b1;
                        beat_d     = {BEAT_W{1'b0}};
                        err_d      = err_q | !s_last;
                    end else if (s_last) begin
                        // Short frame: drop it and remember the error.
                        beat_d = {BEAT_W{1'b0}};
                        err_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_L1: begin
                if (l1_done) begin
                    state_d    = ST_L2;
                    l2_start_d = 1'b1;
                end else begin
                    state_d = ST_L1;
                end
            end
            ST_L2: begin
                if (l2_done) begin
                    state_d = ST_ARG;
                    idx_d   = {CLS_W{1'b0}};
                end else begin
                    state_d = ST_L2;
                end
            end
            ST_ARG: begin
                best_d   = arg_best_s;
                second_d = arg_second_s;
                cls_d    = arg_cls_s;
                if (idx_q == LAST_IDX) begin
                    state_d      = ST_RESULT;
                    idx_d        = {CLS_W{1'b0}};
                    res_valid_d  = 1'b1;
                    res_class_d  = arg_cls_s;
                    res_margin_d = margin_f(arg_best_s, arg_second_s);
                    res_err_d    = err_q;
                    err_d        = 1'b0;
                end else begin
                    idx_d = idx_q + CLS_W'(1);
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_LOAD;
                    res_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                res_valid_d = 1'b0;
            end
        endcase

        if (abort) begin
            state_d     = ST_LOAD;
            beat_d      = {BEAT_W{1'b0}};
            err_d       = 1'b0;
            res_valid_d = 1'b0;
            l1_start_d  = 1'b0;
            l2_start_d  = 1'b0;
            idx_d       = {CLS_W{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            beat_q       <= {BEAT_W{1'b0}};
            err_q        <= 1'b0;
            l1_start_q   <= 1'b0;
            l2_start_q   <= 1'b0;
            idx_q        <= {CLS_W{1'b0}};
            best_q       <= {LOGIT_W{1'b0}};
            second_q     <= {LOGIT_W{1'b0}};
            cls_q        <= {CLS_W{1'b0}};
            res_valid_q  <= 1'b0;
            res_class_q  <= {CLS_W{1'b0}};
            res_margin_q <= {LOGIT_W{1'b0}};
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            l1_start_q   <= l1_start_d;
            l2_start_q   <= l2_start_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            second_q     <= second_d;
            cls_q        <= cls_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_margin_q <= res_margin_d;
            res_err_q    <= res_err_d;
        end
    end

endmodule

// File: doc/nn_infer_seq.md
# nn_infer_seq

Parametrised inference sequencer for the digit-classifier datapath. It accepts an image as a valid/ready pixel stream of any size, bit depth and beat width, and exposes it as a flat vector to the layer engines. It runs the two layer engines back-to-back through start/done pulses, then performs a streaming argmax over N_CLASSES logits. It returns class, confidence margin and frame-error status through a valid/ready result handshake, and supports synchronous abort.

## Interface
- N_PIX, 64: pixels per frame; must be a multiple of PIX_PER_BEAT
- PIX_BITS, 2: bits per pixel (unsigned)
- PIX_PER_BEAT, 4: pixels per input beat
- N_CLASSES, 10: logit count, 2..16
- LOGIT_W, 6: signed logit width
- CLS_W (derived) = clog2(N_CLASSES); BEATS (derived) = N_PIX/PIX_PER_BEAT
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset (decided: one clock, async active-low reset named clk / rst_n)
- s_valid  in  1  pixel beat valid
- s_ready  out  1  sequencer can accept a beat
- s_data  in  PIX_PER_BEAT*PIX_BITS  lane m at [m*PIX_BITS +: PIX_BITS]
- s_last  in  1  marks final beat of frame
- abort  in  1  synchronous flush to LOAD
- pix_flat  out  N_PIX*PIX_BITS  pixel k at [k*PIX_BITS +: PIX_BITS]
- l1_start / l2_start  out  1  one-cycle start pulses to layer engines
- l1_done / l2_done  in  1  one-cycle completion pulses
- logit_addr  out  CLS_W  logit read index
- logit_data  in  LOGIT_W  signed logit, combinational from logit_addr
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_class  out  CLS_W  argmax index
- res_margin  out  LOGIT_W  unsigned max minus second max
- res_err  out  1  frame-length error flag for this result
- busy  out  1  high in L1, L2, ARG

## Operation
- States: LOAD, L1, L2, ARG, RESULT. Reset enters LOAD.
- LOAD: s_ready=1 (combinational on state). Beat counter b runs 0..BEATS-1. Accepted beat (s_valid&s_ready) writes lane m to pixel b*PIX_PER_BEAT+m.
  - s_last on beat b<BEATS-1: frame dropped; counter cleared; stays in LOAD; err_sticky set.
  - Beat BEATS-1 accepted: go to L1 and pulse l1_start. If s_last was low on that beat, err_sticky is set; frame still processed.
- L1: wait for l1_done, then pulse l2_start and go to L2. L2: wait for l2_done, then go to ARG with idx=0.
- done pulses outside their own state are ignored.
- ARG: logit_addr=idx. Per cycle, compare logit_data signed against best and second:
  - idx 0 initialises best=data, second=most-negative.
  - data>best (strict): second=best, best=data, cls=idx.
  - otherwise, data>second: second=data.
  - Ties resolve to the lowest index; equal top logits give margin 0.
  - After idx=N_CLASSES-1: go to RESULT. res_class=cls, res_margin=best-second (fits LOGIT_W unsigned), res_err=err_sticky; err_sticky cleared.
- RESULT: res_valid=1; outputs held stable until res_valid&res_ready, then go to LOAD.
- pix_flat holds the last complete frame from L1 through RESULT. It changes only on accepted beats in LOAD.
- abort: in any state, next state is LOAD. Clears beat counter, err_sticky and res_valid; suppresses pending start pulses. Pixel buffer is not cleared. abort wins over every simultaneous event.

## Timing
- Reset values: s_ready=1 (state LOAD), l1_start=l2_start=0, logit_addr=0, res_valid=0, res_class=0, res_margin=0, res_err=0, busy=0, pix_flat=0.
- l1_start is high in the cycle after the final beat is accepted. l2_start is high in the cycle after l1_done is sampled.
- ARG lasts exactly N_CLASSES cycles. res_valid rises N_CLASSES+1 cycles after l2_done is sampled.
- Sequencer overhead = BEATS + 1 + 1 + N_CLASSES + 1 cycles, excluding engine latency and result back-pressure.
- First beat of the next frame is accepted no earlier than the cycle after the res handshake.
- rst_n assertion mid-frame: immediate return to reset values.

## Test plan
- Defaults; 16 beats of 0xE4 with s_last on beat 15; logits {3,-2,7,7,0,-32,1,6,2,5} -> l1_start one cycle after beat 15; res_class=2, res_margin=0, res_err=0; pix_flat pattern 0,1,2,3 repeating.
- Logits all -32 except index 9 = 31 -> res_class=9, res_margin=63. Hold res_ready=0 for 5 cycles -> outputs stable, s_ready=0.
- s_last on beat 7 -> no l1_start. err flagged on the next full frame's result (res_err=1). The following frame gives res_err=0.
- 16 beats, s_last never asserted -> frame processed, res_err=1.
- abort in L2 coincident with l2_done -> state LOAD, no ARG, res_valid stays 0. A stray l1_done in LOAD is ignored.
- N_PIX=16, PIX_BITS=4, PIX_PER_BEAT=2, N_CLASSES=4, LOGIT_W=8: 8 beats; logits {-1,-128,127,126} -> res_class=2, res_margin=1.
